// File: rtl/psx_state_arbiter.sv
// psx_state_arbiter: round-robin burst arbiter for the psx_controller input-state port.
// Define PSX_ARB_FRAME_LOCK_EN to hold off grants/beats while a PSX packet is in flight.
module psx_state_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic [4:0] a_addr,
  input  logic [4:0] a_len,
  input  logic [7:0] a_data,
  input  logic       a_valid,
  output logic       a_ready,
  output logic       a_grant,
  output logic       a_done,
  output logic       a_abort,
  input  logic       b_req,
  input  logic [4:0] b_addr,
  input  logic [4:0] b_len,
  input  logic [7:0] b_data,
  input  logic       b_valid,
  output logic       b_ready,
  output logic       b_grant,
  output logic       b_done,
  output logic       b_abort,
  input  logic       psx_sel,
  output logic [4:0] write_addr,
  output logic [7:0] write_data,
  output logic       write_en,
  output logic       busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [0:0] state;
  logic       owner_b;
  logic       last_b;
  logic [4:0] addr;
  logic [5:0] remaining;
  logic [15:0] timer;
  logic       sel_ok;
  logic       pick_b;
  logic [4:0] pick_len;
  logic       cur_req;
  logic [7:0] cur_data;
  logic       beat;
  logic       last_beat;
  logic       kill;

`ifdef PSX_ARB_FRAME_LOCK_EN
  logic sel_m;
  logic sel_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_m <= 1'b0;
      sel_s <= 1'b0;
    end else begin
      sel_m <= psx_sel;
      sel_s <= sel_m;
    end
  end

  assign sel_ok = sel_s;
`else
  logic unused_sel;
  assign unused_sel = psx_sel;
  assign sel_ok = 1'b1;
`endif

  assign busy = (state == XFER);
  assign a_grant = busy & ~owner_b;
  assign b_grant = busy & owner_b;
  assign a_ready = a_grant & sel_ok;
  assign b_ready = b_grant & sel_ok;

  // Tie goes to whichever side did not win last time
  assign pick_b = b_req & (~a_req | ~last_b);
  assign pick_len = pick_b ? b_len : a_len;
  assign cur_req = owner_b ? b_req : a_req;
  assign cur_data = owner_b ? b_data : a_data;

  assign beat = (a_ready & a_valid) | (b_ready & b_valid);
  assign last_beat = beat & (remaining == 6'd1);
  assign kill = busy & ~last_beat
              & (~cur_req | (~beat & sel_ok & (timer == TO_LAST)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_b    <= 1'b0;
      last_b     <= 1'b1;
      addr       <= 5'd0;
      remaining  <= 6'd0;
      timer      <= 16'd0;
      write_addr <= 5'd0;
      write_data <= 8'd0;
      write_en   <= 1'b0;
      a_done     <= 1'b0;
      a_abort    <= 1'b0;
      b_done     <= 1'b0;
      b_abort    <= 1'b0;
    end else begin
      write_en <= beat;
      a_done   <= last_beat & ~owner_b;
      b_done   <= last_beat & owner_b;
      a_abort  <= kill & ~owner_b;
      b_abort  <= kill & owner_b;
      if (beat) begin
        write_addr <= addr;
        write_data <= cur_data;
      end
      unique case (state)
        IDLE: begin
          if (sel_ok & (a_req | b_req)) begin
            state     <= XFER;
            owner_b   <= pick_b;
            last_b    <= pick_b;
            addr      <= pick_b ? b_addr : a_addr;
            remaining <= (pick_len == 5'd0) ? 6'd32 : {1'b0, pick_len};
            timer     <= 16'd0;
          end
        end
        XFER: begin
          // Timer only runs while the bus is free to take a byte
          if (beat) begin
            addr      <= addr + 5'd1;
            remaining <= remaining - 6'd1;
            timer     <= 16'd0;
          end else if (sel_ok) begin
            timer <= timer + 16'd1;
          end
          if (last_beat | kill) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psx_state_arbiter.sv
// tb_psx_state_arbiter: scoreboard bench for psx_state_arbiter (TIMEOUT_CYCLES=8).
// Expected writes are queued as beats are driven and popped when write_en appears.
module tb_psx_state_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_valid, a_ready, a_grant, a_done, a_abort;
  logic [4:0] a_addr, a_len;
  logic [7:0] a_data;
  logic       b_req, b_valid, b_ready, b_grant, b_done, b_abort;
  logic [4:0] b_addr, b_len;
  logic [7:0] b_data;
  logic       psx_sel;
  logic [4:0] write_addr;
  logic [7:0] write_data;
  logic       write_en, busy;

  int checks = 0;
  int fails = 0;
  logic [12:0] exp_q[$];
  logic [12:0] mon_exp;

  always #5 clk = ~clk;

  psx_state_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_len(a_len), .a_data(a_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_grant(a_grant),
    .a_done(a_done), .a_abort(a_abort),
    .b_req(b_req), .b_addr(b_addr), .b_len(b_len), .b_data(b_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_grant(b_grant),
    .b_done(b_done), .b_abort(b_abort),
    .psx_sel(psx_sel),
    .write_addr(write_addr), .write_data(write_data),
    .write_en(write_en), .busy(busy)
  );

  always @(negedge clk) begin
    if (!reset && write_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected: got addr=%0d data=%h, required no write",
                 write_addr, write_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({write_addr, write_data} !== mon_exp) begin
          fails++;
          $display("FAIL write_value: got addr=%0d data=%h, required addr=%0d data=%h",
                   write_addr, write_data, mon_exp[12:8], mon_exp[7:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic grant_of(input bit s);
    return s ? b_grant : a_grant;
  endfunction

  function automatic logic ready_of(input bit s);
    return s ? b_ready : a_ready;
  endfunction

  function automatic logic done_of(input bit s);
    return s ? b_done : a_done;
  endfunction

  task automatic set_req(input bit s, input logic v);
    if (s) b_req = v;
    else a_req = v;
  endtask

  task automatic set_beat(input bit s, input logic v, input logic [7:0] d);
    if (s) begin b_valid = v; b_data = d; end
    else begin a_valid = v; a_data = d; end
  endtask

  task automatic wait_grant(input bit s, input string tag);
    bit got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (grant_of(s)) begin got = 1; break; end
    end
    checks++;
    if (!got) begin
      fails++;
      $display("FAIL %s_grant: got no grant for %s within 20 cycles, required grant",
               tag, s ? "B" : "A");
    end
  endtask

  // Drives nb bytes, pushing one expectation per accepted beat
  task automatic run_beats(input bit s, input logic [4:0] start, input int nb,
                           input logic [7:0] seed, input logic [7:0] step,
                           input bit drop, input string tag);
    int i = 0;
    int g = 0;
    logic [4:0] ad;
    logic [7:0] d;
    while (i < nb && g < 64) begin
      d = seed + step * 8'(i);
      set_beat(s, 1'b1, d);
      if (ready_of(s)) begin
        ad = start + 5'(i);
        exp_q.push_back({ad, d});
        i++;
      end
      @(posedge clk);
      #1;
      g++;
    end
    set_beat(s, 1'b0, 8'h00);
    checks++;
    if (i != nb) begin
      fails++;
      $display("FAIL %s_beats: got %0d beats, required %0d", tag, i, nb);
    end
    if (drop) begin
      set_req(s, 1'b0);
      @(negedge clk);
      checks++;
      if (done_of(s) !== 1'b1 || write_en !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL %s_done: got done=%b write_en=%b busy=%b, required 1 1 0",
                 tag, done_of(s), write_en, busy);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    {a_req, a_valid, b_req, b_valid} = '0;
    a_addr = 0; a_len = 0; a_data = 0;
    b_addr = 0; b_len = 0; b_data = 0;
    psx_sel = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_grant, b_grant, a_ready, b_ready, busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, required 00000",
               {a_grant, b_grant, a_ready, b_ready, busy});
    end
    checks++;
    if ({write_addr, write_data, write_en} !== 14'b0) begin
      fails++;
      $display("FAIL reset_write: got %h, required 0", {write_addr, write_data, write_en});
    end
    checks++;
    if ({a_done, a_abort, b_done, b_abort} !== 4'b0) begin
      fails++;
      $display("FAIL reset_pulses: got %b, required 0000",
               {a_done, a_abort, b_done, b_abort});
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_basic;
    a_addr = 5'd4; a_len = 5'd3;
    set_req(0, 1'b1);
    wait_grant(0, "basic");
    checks++;
    if (b_grant !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_owner: got b_grant=%b busy=%b, required 0 1", b_grant, busy);
    end
    run_beats(0, 5'd4, 3, 8'h11, 8'h11, 1, "basic");
  endtask

  task automatic test_round_robin;
    @(posedge clk); #1;
    a_addr = 5'd8; a_len = 5'd2; b_addr = 5'd16; b_len = 5'd2;
    a_req = 1'b1; b_req = 1'b1;
    for (int r = 0; r < 2; r++) begin
      wait_grant(0, "rr_a");
      checks++;
      if (b_grant !== 1'b0) begin
        fails++;
        $display("FAIL rr_excl_a: got b_grant=%b, required 0", b_grant);
      end
      run_beats(0, 5'd8, 2, 8'h40 + 8'(r), 8'h02, 1, "rr_a");
      wait_grant(1, "rr_b");
      checks++;
      if (a_grant !== 1'b0) begin
        fails++;
        $display("FAIL rr_excl_b: got a_grant=%b, required 0", a_grant);
      end
      run_beats(1, 5'd16, 2, 8'h80 + 8'(r), 8'h02, 1, "rr_b");
      if (r == 0) begin a_req = 1'b1; b_req = 1'b1; end
    end
  endtask

  task automatic test_wrap;
    b_addr = 5'd30; b_len = 5'd4;
    set_req(1, 1'b1);
    wait_grant(1, "wrap");
    run_beats(1, 5'd30, 4, 8'hA0, 8'h01, 1, "wrap");
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL wrap_pending: got %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_len0;
    a_addr = 5'd5; a_len = 5'd0;
    set_req(0, 1'b1);
    wait_grant(0, "len0");
    run_beats(0, 5'd5, 32, 8'h00, 8'h03, 1, "len0");
  endtask

  task automatic test_timeout;
    int k;
    a_addr = 5'd0; a_len = 5'd5;
    set_req(0, 1'b1);
    wait_grant(0, "tmo");
    b_addr = 5'd20; b_len = 5'd1;
    set_req(1, 1'b1);
    run_beats(0, 5'd0, 2, 8'h55, 8'h11, 0, "tmo");
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (a_abort) break;
    end
    set_req(0, 1'b0);
    checks++;
    if (k != 9 || a_done !== 1'b0) begin
      fails++;
      $display("FAIL tmo_abort: got abort at cycle %0d done=%b, required cycle 9 done=0",
               k, a_done);
    end
    @(negedge clk);
    checks++;
    if (b_grant !== 1'b1) begin
      fails++;
      $display("FAIL tmo_next: got b_grant=%b, required 1", b_grant);
    end
    run_beats(1, 5'd20, 1, 8'hC3, 8'h00, 1, "tmo_b");
  endtask

  task automatic test_req_drop;
    a_addr = 5'd12; a_len = 5'd4;
    set_req(0, 1'b1);
    wait_grant(0, "drop");
    run_beats(0, 5'd12, 1, 8'h77, 8'h00, 0, "drop");
    set_req(0, 1'b0);
    @(negedge clk);
    checks++;
    if (a_abort !== 1'b0 || write_en !== 1'b1) begin
      fails++;
      $display("FAIL drop_early: got abort=%b write_en=%b, required 0 1", a_abort, write_en);
    end
    @(negedge clk);
    checks++;
    if (a_abort !== 1'b1 || a_grant !== 1'b0 || a_done !== 1'b0) begin
      fails++;
      $display("FAIL drop_abort: got abort=%b grant=%b done=%b, required 1 0 0",
               a_abort, a_grant, a_done);
    end
  endtask

  task automatic test_mid_reset;
    a_addr = 5'd3; a_len = 5'd6;
    set_req(0, 1'b1);
    wait_grant(0, "mreset");
    reset = 1'b1;
    #1;
    checks++;
    if ({a_grant, busy, a_done, a_abort, write_en} !== 5'b0) begin
      fails++;
      $display("FAIL mreset_outputs: got %b, required 00000",
               {a_grant, busy, a_done, a_abort, write_en});
    end
    set_req(0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

`ifdef PSX_ARB_FRAME_LOCK_EN
  task automatic test_frame_lock;
    int k;
    bit bad = 0;
    @(posedge clk); #1 psx_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a_addr = 5'd1; a_len = 5'd4;
    set_req(0, 1'b1);
    repeat (6) @(negedge clk);
    checks++;
    if (a_grant !== 1'b0) begin
      fails++;
      $display("FAIL lock_hold: got a_grant=%b, required 0", a_grant);
    end
    @(posedge clk); #1 psx_sel = 1'b1;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (a_grant) break;
    end
    checks++;
    if (k != 4) begin
      fails++;
      $display("FAIL lock_grant: got grant at cycle %0d, required 4", k);
    end
    fork
      run_beats(0, 5'd1, 4, 8'h90, 8'h01, 1, "lock");
      begin
        repeat (2) @(posedge clk);
        #1 psx_sel = 1'b0;
        repeat (3) @(negedge clk);
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          if (a_ready !== 1'b0 || a_abort !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
          fails++;
          $display("FAIL lock_pause: got ready/abort during packet, required both 0");
        end
        @(posedge clk); #1 psx_sel = 1'b1;
      end
    join
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_wrap();
    test_len0();
    test_timeout();
    test_req_drop();
    test_mid_reset();
`ifdef PSX_ARB_FRAME_LOCK_EN
    test_frame_lock();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL final_pending: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
